mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 54 +++++
 rtl/mem_arbiter_lane_align.sv | 80 ++++++++
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the instruction/data memory arbiter.
//   - arb_state_t       : arbiter FSM state encoding
//   - STARVE_LIMIT_DEF  : default cap on data grants while a fetch waits
//   - MEM_SPACE         : highest word index of the default memory
//   - F3_*              : load/store funct3 encodings
//   - BE_*              : big-endian byte-enable masks (offset 0 = bits [31:24])
//   - d_access_err()    : data access legality check
package mem_arbiter_pkg;

  localparam int MEM_SPACE        = 1023;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_RESP = 2'd1,
    D_RESP = 2'd2
  } arb_state_t;

  // Loads use all five; stores use only B/H/W (SB=000, SH=001, SW=010).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B0 = 4'b1000;  // byte at offset 0, shifted right by offset
  localparam logic [3:0] BE_H0 = 4'b1100;  // halfword at offset 0
  localparam logic [3:0] BE_H2 = 4'b0011;  // halfword at offset 2
  localparam logic [3:0] BE_W  = 4'b1111;

  // Misaligned, reserved funct3 (including unsigned variants on stores) or
  // word index beyond the memory depth.
  function automatic logic d_access_err(input logic        we,
                                        input logic [2:0]  f3,
                                        input logic [31:0] addr,
                                        input int unsigned words);
    logic bad_f3;
    logic misal;
    logic oor;
    bad_f3 = 1'b0;
    misal  = 1'b0;
    case (f3)
      F3_B:    bad_f3 = 1'b0;
      F3_H:    misal  = addr[0];
      F3_W:    misal  = (addr[1:0] != 2'b00);
      F3_BU:   bad_f3 = we;
      F3_HU:   begin bad_f3 = we; misal = addr[0]; end
      default: bad_f3 = 1'b1;
    endcase
    oor = ({2'b00, addr[31:2]} >= words);
    return bad_f3 | misal | oor;
  endfunction

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// mem_lane_align: combinational big-endian lane steering and load extension.
// Ports:
//   i_funct3 [2:0]  access size/sign encoding
//   i_off    [1:0]  byte offset within the word
//   i_wdata  [31:0] right-justified store data
//   i_rdata  [31:0] raw memory word
//   o_be     [3:0]  store byte enables
//   o_wdata  [31:0] lane-replicated store data
//   o_rdata  [31:0] selected and extended load data
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte/halfword; offset 0 is the most significant lane.
  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'b00:   w_byte = i_rdata[31:24];
      2'b01:   w_byte = i_rdata[23:16];
      2'b10:   w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
    if (i_off[1]) begin
      w_half = i_rdata[15:0];
    end else begin
      w_half = i_rdata[31:16];
    end
  end

  // Byte enables, replicated write data and extended read data per size.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0000_0000;
    o_rdata = 32'h0000_0000;
    case (i_funct3)
      F3_B: begin
        o_be    = BE_B0 >> i_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      F3_BU: begin
        o_be    = BE_B0 >> i_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {24'h00_0000, w_byte};
      end
      F3_H: begin
        o_be    = i_off[1] ? BE_H2 : BE_H0;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_half[15]}}, w_half};
      end
      F3_HU: begin
        o_be    = i_off[1] ? BE_H2 : BE_H0;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {16'h0000, w_half};
      end
      F3_W: begin
        o_be    = BE_W;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = 32'h0000_0000;
        o_rdata = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch / data) arbiter onto a single-ported word memory.
// One access outstanding at a time: IDLE issues, I_RESP/D_RESP return data.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   i_req, i_addr                    fetch request (level) and byte address
//   i_valid, i_rdata                 fetch response pulse and word
//   d_req, d_we, d_funct3, d_addr,   data request (level), direction, size,
//   d_wdata                          byte address, right-justified store data
//   d_valid, d_err, d_rdata          data response pulse, error flag, load data
//   mem_en, mem_we, mem_be,          memory strobe, write, byte enables,
//   mem_addr, mem_wdata, mem_rdata   word address, write data, read data (+1 cycle)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int MEM_WORDS    = MEM_SPACE + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int              CW      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT_C = CW'(STARVE_LIMIT);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [CW-1:0] r_starve_cnt;
  logic [2:0]    r_d_funct3;
  logic [1:0]    r_d_off;
  logic          r_d_we;
  logic          r_d_err;

  logic          w_pick_i;
  logic          w_gnt_i;
  logic          w_gnt_d;
  logic          w_d_err;
  logic [2:0]    w_f3_sel;
  logic [1:0]    w_off_sel;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_lane;
  logic [31:0]   w_rdata_ext;
  logic          w_unused_bits;

  // Fetch address bits outside the word index play no part in the access.
  assign w_unused_bits = ^{i_addr[31:12], i_addr[1:0]};

  // Data wins ties until the fetch side has waited STARVE_LIMIT data grants.
  assign w_pick_i = i_req & (~d_req | (r_starve_cnt == LIMIT_C));
  assign w_gnt_i  = (r_state == IDLE) & w_pick_i;
  assign w_gnt_d  = (r_state == IDLE) & d_req & ~w_pick_i;
  assign w_d_err  = d_access_err(d_we, d_funct3, d_addr, MEM_WORDS);

  // The aligner serves the store path while issuing and the load path while
  // responding, so its controls come from the live request or the captured one.
  assign w_f3_sel  = (r_state == D_RESP) ? r_d_funct3 : d_funct3;
  assign w_off_sel = (r_state == D_RESP) ? r_d_off    : d_addr[1:0];

  mem_lane_align u_lane (
    .i_funct3 (w_f3_sel),
    .i_off    (w_off_sel),
    .i_wdata  (d_wdata),
    .i_rdata  (mem_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata_lane),
    .o_rdata  (w_rdata_ext)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt_i) begin
          w_state_nxt = I_RESP;
        end else if (w_gnt_d) begin
          w_state_nxt = D_RESP;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      I_RESP:  w_state_nxt = IDLE;
      D_RESP:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Starvation counter: counts data grants taken over a waiting fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!i_req || w_gnt_i) begin
      r_starve_cnt <= '0;
    end else if (w_gnt_d && (r_starve_cnt != LIMIT_C)) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  // Capture the granted data request so the response does not depend on the
  // requester keeping its inputs stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_funct3 <= 3'b000;
      r_d_off    <= 2'b00;
      r_d_we     <= 1'b0;
      r_d_err    <= 1'b0;
    end else if (w_gnt_d) begin
      r_d_funct3 <= d_funct3;
      r_d_off    <= d_addr[1:0];
      r_d_we     <= d_we;
      r_d_err    <= w_d_err;
    end else begin
      r_d_funct3 <= r_d_funct3;
      r_d_off    <= r_d_off;
      r_d_we     <= r_d_we;
      r_d_err    <= r_d_err;
    end
  end

  // FSM outputs; gated by rst_n so every output is 0 while reset is held.
  always_comb begin
    i_valid   = 1'b0;
    i_rdata   = 32'h0000_0000;
    d_valid   = 1'b0;
    d_err     = 1'b0;
    d_rdata   = 32'h0000_0000;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = 10'd0;
    mem_wdata = 32'h0000_0000;
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          if (w_gnt_i) begin
            mem_en   = 1'b1;
            mem_be   = BE_W;
            mem_addr = i_addr[11:2];
          end else if (w_gnt_d && !w_d_err) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_we ? w_be : BE_W;
            mem_addr  = d_addr[11:2];
            mem_wdata = d_we ? w_wdata_lane : 32'h0000_0000;
          end else begin
            mem_en = 1'b0;
          end
        end
        I_RESP: begin
          i_valid = 1'b1;
          i_rdata = mem_rdata;
        end
        D_RESP: begin
          d_valid = 1'b1;
          d_err   = r_d_err;
          d_rdata = (r_d_err || r_d_we) ? 32'h0000_0000 : w_rdata_ext;
        end
        default: begin
          i_valid = 1'b0;
        end
      endcase
    end else begin
      i_valid = 1'b0;
    end
  end

endmodule
